m_store_unit: RTL and testbench

M_STORE_UNIT -- requirements
Module: m_store_unit

---
 rtl/m_store_unit.sv | 155 +++++++++++++++
 tb/tb_m_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_store_unit.sv
// M-stage store buffer: validates/aligns stores into a 2-entry FIFO that drains to the data bus.
// Latency 1 cycle req->bus (no comb path); req_ready drops when full, head held while bus_ready low.

module m_store_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld,
   output logic         wr_rdy,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wr_rdy = (count != CW'(DEPTH));
   assign rd_vld = (count != '0);
   assign push   = wr_vld & wr_rdy;
   assign pop    = rd_vld & rd_rdy;
   // Empty FIFO presents zeros so nothing stale leaks onto the bus
   assign rd_dat = rd_vld ? mem[head] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail] <= wr_dat;
            tail      <= nxt(tail);
         end
         if (pop) begin
            head <= nxt(head);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module m_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  SEOp,
   input  logic [31:0] SEaddr,
   input  logic [31:0] SEin,
   output logic        Exc_AdES,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_byteen,
   output logic [31:0] bus_wdata,
   output logic        busy
);
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  byteen;
      logic [31:0] wdata;
   } st_entry_t;

   logic      is_sw;
   logic      is_sh;
   logic      is_sb;
   logic      is_store;
   logic      in_dm;
   logic      in_tc0;
   logic      in_tc1;
   logic      in_irq;
   logic      in_cnt;
   logic      err_align;
   logic      err_range;
   logic      err_timer;
   logic      enq_vld;
   st_entry_t new_ent;
   st_entry_t head_ent;

   assign is_sw    = (SEOp == 3'd1);
   assign is_sh    = (SEOp == 3'd2);
   assign is_sb    = (SEOp == 3'd3);
   assign is_store = is_sw | is_sh | is_sb;

   assign in_dm  = (SEaddr <= 32'h0000_2FFF);
   assign in_tc0 = (SEaddr >= 32'h0000_7F00) && (SEaddr <= 32'h0000_7F0B);
   assign in_tc1 = (SEaddr >= 32'h0000_7F10) && (SEaddr <= 32'h0000_7F1B);
   assign in_irq = (SEaddr >= 32'h0000_7F20) && (SEaddr <= 32'h0000_7F23);
   // Timer count registers are read-only from software
   assign in_cnt = ((SEaddr >= 32'h0000_7F08) && (SEaddr <= 32'h0000_7F0B)) ||
                   ((SEaddr >= 32'h0000_7F18) && (SEaddr <= 32'h0000_7F1B));

   assign err_align = (is_sw && (SEaddr[1:0] != 2'b00)) || (is_sh && SEaddr[0]);
   assign err_range = !(in_dm || in_tc0 || in_tc1 || in_irq);
   assign err_timer = ((is_sh || is_sb) && (SEaddr >= 32'h0000_7F00) && (SEaddr <= 32'h0000_7F1B)) ||
                      in_cnt;

   assign Exc_AdES = req_valid & is_store & (err_align | err_range | err_timer);
   assign enq_vld  = req_valid & is_store & ~Exc_AdES;

   always_comb begin
      new_ent      = '0;
      new_ent.addr = {SEaddr[31:2], 2'b00};
      if (is_sw) begin
         new_ent.byteen = 4'b1111;
         new_ent.wdata  = SEin;
      end else if (is_sh) begin
         new_ent.byteen = SEaddr[1] ? 4'b1100 : 4'b0011;
         new_ent.wdata  = {2{SEin[15:0]}};
      end else if (is_sb) begin
         new_ent.byteen = 4'b0001 << SEaddr[1:0];
         new_ent.wdata  = {4{SEin[7:0]}};
      end
   end

   m_store_fifo #(
      .W     ($bits(st_entry_t)),
      .DEPTH (2)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (enq_vld),
      .wr_rdy (req_ready),
      .wr_dat (new_ent),
      .rd_vld (bus_valid),
      .rd_rdy (bus_ready),
      .rd_dat (head_ent)
   );

   assign bus_addr   = head_ent.addr;
   assign bus_byteen = head_ent.byteen;
   assign bus_wdata  = head_ent.wdata;
   assign busy       = bus_valid;
endmodule

// File: tb/tb_m_store_unit.sv
// Bench for m_store_unit: queue-based reference model compared every cycle, plus directed literal checks.

module tb_m_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  SEOp;
   logic [31:0] SEaddr;
   logic [31:0] SEin;
   logic        Exc_AdES;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic [3:0]  bus_byteen;
   logic [31:0] bus_wdata;
   logic        busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;
   ent_t q[$];

   m_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .SEOp       (SEOp),
      .SEaddr     (SEaddr),
      .SEin       (SEin),
      .Exc_AdES   (Exc_AdES),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .bus_addr   (bus_addr),
      .bus_byteen (bus_byteen),
      .bus_wdata  (bus_wdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exc_model(input bit v, input logic [2:0] op, input logic [31:0] a);
      bit st       = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
      bit mis      = (op == 3'd1 && (a % 4) != 0) || (op == 3'd2 && (a % 2) != 0);
      bit legal    = (a < 32'h3000) || (a >= 32'h7F00 && a < 32'h7F0C) ||
                     (a >= 32'h7F10 && a < 32'h7F1C) || (a >= 32'h7F20 && a < 32'h7F24);
      bit in_timer = (a >= 32'h7F00 && a < 32'h7F1C);
      bit cnt_reg  = in_timer && ((a - 32'h7F00) % 16) >= 8;
      bit timer    = (in_timer && op != 3'd1) || cnt_reg;
      return v && st && (mis || !legal || timer);
   endfunction

   function automatic ent_t make_ent(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      ent_t e;
      e.a = a - (a % 4);
      if (op == 3'd1) begin
         e.be = 4'hF;
         e.d  = d;
      end else if (op == 3'd2) begin
         e.be = a[1] ? 4'hC : 4'h3;
         e.d  = d[15:0] * 32'h0001_0001;
      end else begin
         e.be = 4'(1 << (a % 4));
         e.d  = d[7:0] * 32'h0101_0101;
      end
      return e;
   endfunction

   // Reference model: state changes on the clock, cleared asynchronously
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
      end else begin
         bit do_enq;
         do_enq = req_valid && (SEOp inside {3'd1, 3'd2, 3'd3}) &&
                  !exc_model(req_valid, SEOp, SEaddr) && (q.size() < 2);
         if (q.size() > 0 && bus_ready) void'(q.pop_front());
         if (do_enq) q.push_back(make_ent(SEOp, SEaddr, SEin));
      end
   end

   always @(negedge clk) begin
      chk("m_req_ready", 32'(req_ready), 32'(q.size() != 2));
      chk("m_bus_valid", 32'(bus_valid), 32'(q.size() != 0));
      chk("m_busy",      32'(busy),      32'(q.size() != 0));
      chk("m_exc",       32'(Exc_AdES),  32'(exc_model(req_valid, SEOp, SEaddr)));
      if (q.size() != 0) begin
         chk("m_bus_addr",   bus_addr,          q[0].a);
         chk("m_bus_byteen", 32'(bus_byteen),   32'(q[0].be));
         chk("m_bus_wdata",  bus_wdata,         q[0].d);
      end else begin
         chk("m_idle_bus", {bus_addr[31:4], bus_addr[3:0] | bus_byteen} ^ 32'h0, 32'h0);
         chk("m_idle_wdata", bus_wdata, 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      SEOp      = op;
      SEaddr    = a;
      SEin      = d;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic        br;
   } vec_t;
   vec_t vecs[10];

   initial begin
      reset     = 1'b0;
      bus_ready = 1'b0;
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      step();
      step();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_bus_addr",  bus_addr,       32'h0);
      reset = 1'b1;
      step();

      // sb to byte 3
      bus_ready = 1'b1;
      drive(1'b1, 3'd3, 32'h0000_0013, 32'h1234_56AB);
      #1;
      chk("sb_exc", 32'(Exc_AdES), 32'd0);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      chk("sb_bus_valid",  32'(bus_valid),  32'd1);
      chk("sb_bus_addr",   bus_addr,        32'h0000_0010);
      chk("sb_bus_byteen", 32'(bus_byteen), 32'b1000);
      chk("sb_bus_wdata",  bus_wdata,       32'hABAB_ABAB);
      step();
      chk("sb_drained", 32'(bus_valid), 32'd0);

      // Exceptions
      bus_ready = 1'b0;
      drive(1'b1, 3'd2, 32'h0000_0001, 32'h5555);
      #1;
      chk("sh_misalign_exc", 32'(Exc_AdES), 32'd1);
      step();
      chk("sh_misalign_busy", 32'(busy), 32'd0);
      drive(1'b1, 3'd1, 32'h0000_7F08, 32'h1);
      #1;
      chk("sw_cnt_exc", 32'(Exc_AdES), 32'd1);
      drive(1'b1, 3'd3, 32'h0000_7F04, 32'h1);
      #1;
      chk("sb_timer_exc", 32'(Exc_AdES), 32'd1);
      drive(1'b1, 3'd1, 32'h0000_3000, 32'h1);
      #1;
      chk("sw_range_exc", 32'(Exc_AdES), 32'd1);
      drive(1'b1, 3'd5, 32'h0000_0000, 32'h1);
      #1;
      chk("op5_exc", 32'(Exc_AdES), 32'd0);
      step();
      chk("op5_busy", 32'(busy), 32'd0);
      drive(1'b1, 3'd1, 32'h0000_7F04, 32'h0000_00C3);
      #1;
      chk("sw_preset_exc", 32'(Exc_AdES), 32'd0);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      chk("sw_preset_addr", bus_addr, 32'h0000_7F04);
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;

      // Fill to full with bus stalled
      drive(1'b1, 3'd1, 32'h0000_0100, 32'hA1A1_A1A1);
      step();
      drive(1'b1, 3'd1, 32'h0000_0104, 32'hA2A2_A2A2);
      step();
      drive(1'b1, 3'd1, 32'h0000_0108, 32'hA3A3_A3A3);
      #1;
      chk("full_req_ready", 32'(req_ready), 32'd0);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      chk("full_hold_wdata", bus_wdata, 32'hA1A1_A1A1);
      bus_ready = 1'b1;
      step();
      chk("drain2_wdata",    bus_wdata,       32'hA2A2_A2A2);
      chk("drain2_req_ready", 32'(req_ready), 32'd1);
      step();
      chk("drain_done", 32'(bus_valid), 32'd0);

      // Simultaneous enqueue/dequeue at count 1
      bus_ready = 1'b0;
      drive(1'b1, 3'd1, 32'h0000_0200, 32'hB1B1_B1B1);
      step();
      drive(1'b1, 3'd1, 32'h0000_0204, 32'hB2B2_B2B2);
      bus_ready = 1'b1;
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      bus_ready = 1'b0;
      chk("swap_valid", 32'(bus_valid), 32'd1);
      chk("swap_wdata", bus_wdata,      32'hB2B2_B2B2);
      chk("swap_addr",  bus_addr,       32'h0000_0204);
      chk("swap_ready", 32'(req_ready), 32'd1);
      bus_ready = 1'b1;
      step();
      bus_ready = 1'b0;

      // Reset mid-cycle while full
      drive(1'b1, 3'd1, 32'h0000_0300, 32'hC1C1_C1C1);
      step();
      drive(1'b1, 3'd1, 32'h0000_0304, 32'hC2C2_C2C2);
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      chk("prerst_ready", 32'(req_ready), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(bus_valid), 32'd0);
      chk("rst_mid_wdata", bus_wdata,      32'h0);
      step();
      reset     = 1'b1;
      bus_ready = 1'b1;
      step();
      chk("postrst_busy",  32'(busy),      32'd0);
      chk("postrst_ready", 32'(req_ready), 32'd1);
      step();
      chk("postrst_valid", 32'(bus_valid), 32'd0);

      // Mixed vectors, checked by the model
      vecs[0] = '{3'd1, 32'h0000_2FFC, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{3'd2, 32'h0000_0102, 32'h0000_CAFE, 1'b0};
      vecs[2] = '{3'd3, 32'h0000_0005, 32'h0000_0077, 1'b1};
      vecs[3] = '{3'd2, 32'h0000_7F20, 32'h0000_1111, 1'b1};
      vecs[4] = '{3'd1, 32'h0000_7F14, 32'h0000_2222, 1'b0};
      vecs[5] = '{3'd3, 32'h0000_7F21, 32'h0000_0033, 1'b1};
      vecs[6] = '{3'd1, 32'h0000_7F18, 32'h0000_0044, 1'b1};
      vecs[7] = '{3'd4, 32'h0000_0000, 32'h0000_0055, 1'b1};
      vecs[8] = '{3'd1, 32'h0000_7F22, 32'h0000_0066, 1'b0};
      vecs[9] = '{3'd3, 32'h0000_3000, 32'h0000_0088, 1'b1};
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].d);
         bus_ready = vecs[i].br;
         step();
      end
      drive(1'b0, 3'd0, 32'h0, 32'h0);
      bus_ready = 1'b1;
      step();
      step();
      step();
      chk("final_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
